// File: rtl/ram_refresh_arbiter.sv
// DRAM refresh scheduler and CPU/refresh arbiter between the FSB access logic
// and the RAS/CAS sequencer. Refresh requests are banked; the CPU wins until the bank is full.
//
//  state | meaning
//  IDLE  | RAM free, choosing between a banked refresh and the CPU
//  CPU   | CPU owns the RAM until CPUDone or CPUReq drops
//  REF   | RAS-only refresh running for REF_LEN cycles
//  REC   | post-refresh recovery, nobody granted for REC_LEN cycles
module ram_refresh_arbiter #(
    parameter int REF_INTERVAL = 128,
    parameter int REF_LEN      = 4,
    parameter int REC_LEN      = 2,
    parameter int MAX_PEND     = 4,
    parameter int PEND_W       = 3
) (
    input  logic              FCLK,
    input  logic              nRES,
    input  logic              RefEN,
    input  logic              CPUReq,
    input  logic              CPUDone,
    output logic              CPUGnt,
    output logic              RefActive,
    output logic              RefUrgent,
    output logic [PEND_W-1:0] RefPend
);

    localparam int IC_W   = $clog2(REF_INTERVAL);
    localparam int PH_MAX = (REF_LEN > REC_LEN) ? REF_LEN : REC_LEN;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [IC_W-1:0]   IC_LAST  = IC_W'(REF_INTERVAL - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
    localparam logic [PH_W-1:0]   REF_LOAD = PH_W'(REF_LEN - 1);
    localparam logic [PH_W-1:0]   REC_LOAD = PH_W'(REC_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_REF  = 2'd2,
        ST_REC  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IC_W-1:0]     ic_q, ic_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic                gnt_q, gnt_d;
    logic                act_q, act_d;
    logic                tick;
    logic                ref_start;
    logic                urgent;

    assign urgent = (pend_q == PEND_MAX);

    // Interval counter: free-running while enabled, held at zero otherwise.
    always_comb begin
        tick = RefEN && (ic_q == IC_LAST);
        ic_d = '0;
        if (RefEN && !tick) begin
            ic_d = ic_q + IC_W'(1);
        end
    end

    // The phase counter is a down-counter loaded on state entry; zero is terminal count.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        ref_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((pend_q != '0) && (urgent || !CPUReq)) begin
                    state_d   = ST_REF;
                    phase_d   = REF_LOAD;
                    ref_start = 1'b1;
                end else if (CPUReq) begin
                    state_d = ST_CPU;
                end
            end
            ST_CPU: begin
                if (CPUDone || !CPUReq) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REF: begin
                if (phase_q == '0) begin
                    state_d = ST_REC;
                    phase_d = REC_LOAD;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            ST_REC: begin
                if (phase_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A tick coinciding with a refresh start cancels out; ticks beyond saturation are dropped.
    always_comb begin
        pend_d = pend_q;
        if (tick && !ref_start) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (ref_start && !tick) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    // Outputs come straight off flops so the sequencer sees glitch-free strobes.
    always_comb begin
        gnt_d = (state_d == ST_CPU);
        act_d = (state_d == ST_REF);
    end

    always_ff @(posedge FCLK) begin
        if (!nRES) begin
            state_q <= ST_IDLE;
            ic_q    <= '0;
            pend_q  <= '0;
            phase_q <= '0;
            gnt_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
            pend_q  <= pend_d;
            phase_q <= phase_d;
            gnt_q   <= gnt_d;
            act_q   <= act_d;
        end
    end

    assign CPUGnt    = gnt_q;
    assign RefActive = act_q;
    assign RefUrgent = urgent;
    assign RefPend   = pend_q;

endmodule
